// File: rtl/fdiv_seq.sv
// Multicycle binary32 divider: radix-2 restoring mantissa iteration, RNE rounding,
// fixed latency of ITER+2 cycles from accept to done for every operand class.
module fdiv_seq #(
    parameter int ITER = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] s,
    output logic        invalid,
    output logic        DZ,
    output logic        OF,
    output logic        UF,
    output logic        NX
);
    // Handshake: start is accepted only on a rising edge where busy=0; busy then stays
    // high through the single-cycle done pulse, so start during the done cycle is dropped.
    typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;
    localparam logic [4:0] LAST = 5'(ITER - 1);

    state_t             state;
    logic [4:0]         cnt;
    logic               sign;
    logic [7:0]         ea, eb;
    logic [23:0]        mb;
    logic [24:0]        r;
    logic [ITER-1:0]    q;
    logic               sp;
    logic [31:0]        sp_s;
    logic               sp_inv, sp_dz;

    // operand classification at accept; subnormals count as zero
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic        cls_sp, cls_inv, cls_dz;
    logic [31:0] cls_s;

    always_comb begin
        a_zero  = (a[30:23] == 8'd0);
        b_zero  = (b[30:23] == 8'd0);
        a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_snan  = a_nan && !a[22];
        b_snan  = b_nan && !b[22];
        cls_sp  = 1'b1;
        cls_inv = 1'b0;
        cls_dz  = 1'b0;
        cls_s   = {a[31] ^ b[31], 31'd0};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            cls_s   = 32'h7FC00000;
            cls_inv = a_snan || b_snan || (a_zero && b_zero) || (a_inf && b_inf);
        end else if (b_zero) begin
            cls_s  = {a[31] ^ b[31], 8'hFF, 23'd0};
            cls_dz = !a_inf;
        end else if (a_inf) begin
            cls_s = {a[31] ^ b[31], 8'hFF, 23'd0};
        end else if (b_inf || a_zero) begin
            cls_s = {a[31] ^ b[31], 31'd0};
        end else begin
            cls_sp = 1'b0;
        end
    end

    logic        ge;
    logic [24:0] rsub;

    always_comb begin
        ge   = (r >= {1'b0, mb});
        rsub = ge ? (r - {1'b0, mb}) : r;
    end

    // normalise and round; with q[msb]=1 the bit below guard joins the sticky
    logic        msb, guard, sticky, inc, carry, ovf, unf;
    logic [22:0] frac_pre;
    logic [23:0] frac_sum;
    logic [9:0]  e_pre, e_fin;

    always_comb begin
        msb      = q[ITER-1];
        frac_pre = msb ? q[ITER-2 -: 23] : q[ITER-3 -: 23];
        guard    = msb ? q[1] : q[0];
        sticky   = (r != 25'd0) || (msb && q[0]);
        e_pre    = {2'b00, ea} - {2'b00, eb} + (msb ? 10'd127 : 10'd126);
        inc      = guard && (sticky || frac_pre[0]);
        frac_sum = {1'b0, frac_pre} + {23'd0, inc};
        carry    = frac_sum[23];
        e_fin    = e_pre + {9'd0, carry};
        ovf      = ($signed(e_fin) >= 10'sd255);
        unf      = ($signed(e_fin) <= 10'sd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= 32'd0;
            invalid <= 1'b0;
            DZ      <= 1'b0;
            OF      <= 1'b0;
            UF      <= 1'b0;
            NX      <= 1'b0;
            sign    <= 1'b0;
            ea      <= 8'd0;
            eb      <= 8'd0;
            mb      <= 24'd0;
            r       <= 25'd0;
            q       <= '0;
            sp      <= 1'b0;
            sp_s    <= 32'd0;
            sp_inv  <= 1'b0;
            sp_dz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start && !busy) begin
                        busy    <= 1'b1;
                        state   <= DIV;
                        cnt     <= 5'd0;
                        invalid <= 1'b0;
                        DZ      <= 1'b0;
                        OF      <= 1'b0;
                        UF      <= 1'b0;
                        NX      <= 1'b0;
                        sign    <= a[31] ^ b[31];
                        ea      <= a[30:23];
                        eb      <= b[30:23];
                        mb      <= {1'b1, b[22:0]};
                        r       <= {2'b01, a[22:0]};
                        q       <= '0;
                        sp      <= cls_sp;
                        sp_s    <= cls_s;
                        sp_inv  <= cls_inv;
                        sp_dz   <= cls_dz;
                    end
                end
                DIV: begin
                    q   <= {q[ITER-2:0], ge};
                    r   <= {rsub[23:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) state <= ROUND;
                end
                ROUND: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (sp) begin
                        s       <= sp_s;
                        invalid <= sp_inv;
                        DZ      <= sp_dz;
                    end else if (ovf) begin
                        s  <= {sign, 8'hFF, 23'd0};
                        OF <= 1'b1;
                        NX <= 1'b1;
                    end else if (unf) begin
                        s  <= {sign, 31'd0};
                        UF <= 1'b1;
                        NX <= 1'b1;
                    end else begin
                        s  <= {sign, e_fin[7:0], frac_sum[22:0]};
                        NX <= guard || sticky;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
